// File: rtl/bsg_mem_pkg.sv
// rtl/bsg_mem_pkg.sv - shared types and lane mapping helper for the lane-read RAM
package bsg_mem_pkg;

  typedef enum logic {CLEAR, IDLE} mem_state_e;

  // Lane 0 occupies the most significant slice of the read word.
  function automatic int lane_lsb(input int lane, input int lanes, input int width);
    return (lanes - 1 - lane) * width;
  endfunction

endpackage

// File: rtl/bsg_mem_lane_addr_gen.sv
// rtl/bsg_mem_lane_addr_gen.sv - consecutive lane addresses from a base, wrapping modulo els_p
module bsg_mem_lane_addr_gen
  import bsg_mem_pkg::*;
#(
  parameter int els_p        = 16,
  parameter int lanes_p      = 2,
  parameter int addr_width_p = 4
) (
  input  logic [addr_width_p-1:0]              base_i,
  output logic [lanes_p-1:0][addr_width_p-1:0] addr_o
);

  localparam logic [addr_width_p:0] els_lp = (addr_width_p + 1)'(els_p);

  // base + k stays below 2*els_p, so one compare-and-subtract suffices.
  always_comb begin : p_gen
    logic [addr_width_p:0] sum;
    addr_o = '0;
    sum    = '0;
    for (int k = 0; k < lanes_p; k++) begin
      sum = {1'b0, base_i} + (addr_width_p + 1)'(k);
      if (sum >= els_lp) begin
        sum = sum - els_lp;
      end
      addr_o[k] = sum[addr_width_p-1:0];
    end
  end

endmodule

// File: rtl/bsg_mem_1r1w_sync_lanes.sv
// rtl/bsg_mem_1r1w_sync_lanes.sv - 1r1w RAM with registered multi-lane read and optional clear
module bsg_mem_1r1w_sync_lanes
  import bsg_mem_pkg::*;
#(
  parameter int width_p                = 32,
  parameter int els_p                  = 16,
  parameter int lanes_p                = 2,
  parameter bit read_write_same_addr_p = 1'b0,
  parameter bit clear_on_reset_p       = 1'b0,
  localparam int addr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  output logic                       ready_o,
  input  logic                       w_v_i,
  input  logic [addr_width_lp-1:0]   w_addr_i,
  input  logic [width_p-1:0]         w_data_i,
  input  logic                       r_v_i,
  input  logic [addr_width_lp-1:0]   r_addr_i,
  output logic                       r_v_o,
  output logic [lanes_p*width_p-1:0] r_data_o
);

  if (lanes_p < 1 || lanes_p > els_p) begin : g_bad_lanes
    $fatal(1, "lanes_p must lie in [1, els_p]");
  end
  if (width_p < 1) begin : g_bad_width
    $fatal(1, "width_p must be at least 1");
  end
  if (els_p < 1) begin : g_bad_els
    $fatal(1, "els_p must be at least 1");
  end

  localparam logic [addr_width_lp:0]   els_lp  = (addr_width_lp + 1)'(els_p);
  localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);

  logic [width_p-1:0] mem_q [els_p];

  mem_state_e                 state_q, state_d;
  logic [addr_width_lp-1:0]   cnt_q, cnt_d;
  logic                       ready_q, ready_d;
  logic                       r_v_q, r_v_d;
  logic [lanes_p*width_p-1:0] r_data_q, r_data_d;

  logic                       mem_we;
  logic [addr_width_lp-1:0]   mem_waddr;
  logic [width_p-1:0]         mem_wdata;

  logic [lanes_p-1:0][addr_width_lp-1:0] lane_addr;

  logic w_in_range, r_in_range, w_acc, r_acc;

  assign w_in_range = ({1'b0, w_addr_i} < els_lp);
  assign r_in_range = ({1'b0, r_addr_i} < els_lp);
  assign w_acc      = w_v_i & ready_q & w_in_range;
  assign r_acc      = r_v_i & ready_q;

  bsg_mem_lane_addr_gen #(
    .els_p       (els_p),
    .lanes_p     (lanes_p),
    .addr_width_p(addr_width_lp)
  ) u_addr_gen (
    .base_i(r_addr_i),
    .addr_o(lane_addr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = w_addr_i;
    mem_wdata = w_data_i;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (cnt_q == last_lp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE:    mem_we = w_acc;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Without a read the output register holds, even if the entries are rewritten.
  always_comb begin : p_read
    logic [width_p-1:0] lane;
    r_v_d    = r_acc;
    r_data_d = r_data_q;
    lane     = '0;
    if (r_acc) begin
      for (int k = 0; k < lanes_p; k++) begin
        lane = '0;
        if (r_in_range) begin
          lane = mem_q[lane_addr[k]];
          if (read_write_same_addr_p && w_acc && (w_addr_i == lane_addr[k])) begin
            lane = w_data_i;
          end
        end
        r_data_d[lane_lsb(k, lanes_p, width_p) +: width_p] = lane;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (clear_on_reset_p) begin
        state_q <= CLEAR;
      end else begin
        state_q <= IDLE;
      end
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      r_v_q    <= 1'b0;
      r_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      r_v_q    <= r_v_d;
      r_data_q <= r_data_d;
    end
  end

  assign ready_o  = ready_q;
  assign r_v_o    = r_v_q;
  assign r_data_o = r_data_q;

  always @(posedge clk_i) begin
    if (rst_ni && ready_q) begin
      if (w_v_i) assert (w_in_range) else $error("write address %0d out of range", w_addr_i);
      if (r_v_i) assert (r_in_range) else $error("read address %0d out of range", r_addr_i);
      if (!read_write_same_addr_p && r_v_i && w_v_i && w_in_range) begin
        for (int k = 0; k < lanes_p; k++) begin
          assert (lane_addr[k] != w_addr_i)
            else $warning("read/write collision on lane %0d, returning pre-write data", k);
        end
      end
    end
  end

endmodule
